// File: rtl/sram_scheduler.sv
// Shares one asynchronous 8-bit SRAM between the ULA video fetch port and the Z80 port.
// A fixed-priority arbiter with a starvation guard runs complete read and write slots.
module sram_scheduler #(
    parameter int AW           = 19,
    parameter int STARVE_LIMIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic          v_ack,
    output logic [7:0]    v_dout,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [7:0]    c_din,
    output logic          c_ack,
    output logic [7:0]    c_dout,
    output logic [AW-1:0] sram_addr,
    inout  wire  [7:0]    sram_data,
    output logic          sram_we_n,
    output logic          busy
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2,
        WR3,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic          grant_v, grant_c;
    logic          cpu_owner_reg;
    logic [7:0]    wdata_reg;
    logic          drive_reg;
    logic          we_n_reg;
    logic [AW-1:0] sram_addr_reg;
    logic          v_ack_reg, c_ack_reg;
    logic [7:0]    v_dout_reg, c_dout_reg;
    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;

    // Arbitration and next-state: video has priority until the CPU has waited out its limit.
    always_comb begin
        state_next      = state_reg;
        grant_v         = 1'b0;
        grant_c         = 1'b0;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (v_req && c_req) begin
                    if (starve_cnt_reg == STARVE_MAX) begin
                        grant_c = 1'b1;
                    end else begin
                        grant_v = 1'b1;
                    end
                end else if (v_req) begin
                    grant_v = 1'b1;
                end else if (c_req) begin
                    grant_c = 1'b1;
                end
                if (grant_v) begin
                    state_next = RD1;
                end else if (grant_c) begin
                    state_next = c_we ? WR1 : RD1;
                end
            end
            RD1:     state_next = RD2;
            RD2:     state_next = DONE;
            WR1:     state_next = WR2;
            WR2:     state_next = WR3;
            WR3:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (grant_c) begin
            starve_cnt_next = '0;
        end else if (grant_v && c_req) begin
            if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end else if (state_reg == IDLE && !c_req) begin
            starve_cnt_next = '0;
        end
    end

    // Pin-facing controls are decoded from state_next so they leave flops aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cpu_owner_reg  <= 1'b0;
            wdata_reg      <= 8'h00;
            drive_reg      <= 1'b0;
            we_n_reg       <= 1'b1;
            sram_addr_reg  <= '0;
            v_ack_reg      <= 1'b0;
            c_ack_reg      <= 1'b0;
            v_dout_reg     <= 8'h00;
            c_dout_reg     <= 8'h00;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            we_n_reg       <= (state_next != WR2);
            drive_reg      <= (state_next == WR1) || (state_next == WR2) || (state_next == WR3);
            v_ack_reg      <= (state_reg == RD2) && !cpu_owner_reg;
            c_ack_reg      <= ((state_reg == RD2) && cpu_owner_reg) || (state_reg == WR3);

            if (grant_v) begin
                sram_addr_reg <= v_addr;
                cpu_owner_reg <= 1'b0;
            end else if (grant_c) begin
                sram_addr_reg <= c_addr;
                cpu_owner_reg <= 1'b1;
                wdata_reg     <= c_din;
            end

            if (state_reg == RD2) begin
                if (cpu_owner_reg) begin
                    c_dout_reg <= sram_data;
                end else begin
                    v_dout_reg <= sram_data;
                end
            end
        end
    end

    assign sram_data = drive_reg ? wdata_reg : 8'hzz;
    assign sram_we_n = we_n_reg;
    assign sram_addr = sram_addr_reg;
    assign v_ack     = v_ack_reg;
    assign c_ack     = c_ack_reg;
    assign v_dout    = v_dout_reg;
    assign c_dout    = c_dout_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_scheduler.sv
// Self-checking bench for sram_scheduler: directed slot timing plus randomized two-port traffic
// compared against a transaction-level arbitration and memory model.
module tb_sram_scheduler;

    localparam int AW  = 19;
    localparam int LIM = 2;

    typedef struct packed {
        logic          port;   // 0 = video, 1 = CPU
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          v_ack;
    logic [7:0]    v_dout;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_din;
    logic          c_ack;
    logic [7:0]    c_dout;
    logic [AW-1:0] sram_addr;
    wire  [7:0]    sram_data;
    logic          sram_we_n;
    logic          busy;

    logic          tb_drive;
    logic [7:0]    rd_q;
    logic [7:0]    sram_mem [logic [AW-1:0]];
    logic [7:0]    ref_mem  [logic [AW-1:0]];
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    exp_v_dout;
    logic [7:0]    exp_c_dout;
    logic          got_order[$];

    sram_scheduler #(.AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .v_req     (v_req),
        .v_addr    (v_addr),
        .v_ack     (v_ack),
        .v_dout    (v_dout),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_din     (c_din),
        .c_ack     (c_ack),
        .c_dout    (c_dout),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: outputs only while the bench enables it and WE is high.
    assign sram_data = (tb_drive && sram_we_n) ? rd_q : 8'hzz;

    function automatic logic [7:0] mem_default(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    function automatic logic [7:0] sram_peek(input logic [AW-1:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return mem_default(a);
    endfunction

    function automatic logic [7:0] ref_peek(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_default(a);
    endfunction

    always @(negedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] = sram_data;
        rd_q = sram_peek(sram_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; v_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
        v_addr = '0; c_addr = '0; c_din = 8'h00; tb_drive = 1'b0;
        tick(); tick();
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
        checks++; if ({v_ack, c_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {v_ack, c_ack}); end
        checks++; if ({v_dout, c_dout} !== 16'h0000) begin errors++; $display("FAIL reset_douts: got %h expected 0000", {v_dout, c_dout}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if ({busy, sram_we_n} !== 2'b01) begin errors++; $display("FAIL reset_release: busy/we_n got %b expected 01", {busy, sram_we_n}); end
        exp_v_dout = 8'h00;
        exp_c_dout = 8'h00;
        $display("txn reset: scheduler idle after release");
    endtask

    task automatic test_write_read;
        logic [AW-1:0] a;
        a = 19'h1_2345;
        c_req = 1'b1; c_we = 1'b1; c_addr = a; c_din = 8'hA5; tb_drive = 1'b0;
        tick();  // grant edge E0
        checks++; if ({busy, sram_we_n, sram_addr, sram_data} !== {1'b1, 1'b1, a, 8'hA5})
            begin errors++; $display("FAIL wr_setup: busy/we_n/addr/data got %b/%b/%h/%h expected 1/1/%h/a5", busy, sram_we_n, sram_addr, sram_data, a); end
        c_addr = ~a; c_din = 8'h00; c_we = 1'b0;
        tick();  // E1
        checks++; if ({sram_we_n, sram_addr, sram_data, c_ack} !== {1'b0, a, 8'hA5, 1'b0})
            begin errors++; $display("FAIL wr_pulse: we_n/addr/data/ack got %b/%h/%h/%b expected 0/%h/a5/0", sram_we_n, sram_addr, sram_data, c_ack, a); end
        tick();  // E2
        checks++; if ({sram_we_n, sram_addr, sram_data, c_ack} !== {1'b1, a, 8'hA5, 1'b0})
            begin errors++; $display("FAIL wr_hold: we_n/addr/data/ack got %b/%h/%h/%b expected 1/%h/a5/0", sram_we_n, sram_addr, sram_data, c_ack, a); end
        tick();  // E3
        checks++; if ({c_ack, sram_we_n} !== 2'b11) begin errors++; $display("FAIL wr_ack: ack/we_n got %b expected 11", {c_ack, sram_we_n}); end
        checks++; if (sram_data === 8'hA5) begin errors++; $display("FAIL wr_release: data still driven %h", sram_data); end
        checks++; if (c_dout !== exp_c_dout) begin errors++; $display("FAIL wr_cdout: got %h expected %h", c_dout, exp_c_dout); end
        c_req = 1'b0;
        tick();
        checks++; if ({c_ack, busy} !== 2'b00) begin errors++; $display("FAIL wr_done: ack/busy got %b expected 00", {c_ack, busy}); end
        checks++; if (sram_peek(a) !== 8'hA5) begin errors++; $display("FAIL wr_mem: got %h expected a5", sram_peek(a)); end
        ref_mem[a] = 8'hA5;
        $display("txn cpu wr addr=%h data=a5", a);

        c_req = 1'b1; c_we = 1'b0; c_addr = a; tb_drive = 1'b1;
        tick();  // E0
        checks++; if ({sram_addr, sram_we_n, c_ack} !== {a, 1'b1, 1'b0})
            begin errors++; $display("FAIL rd_addr: addr/we_n/ack got %h/%b/%b expected %h/1/0", sram_addr, sram_we_n, c_ack, a); end
        c_addr = '0; c_we = 1'b1;
        tick();  // E1
        checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b expected 0", c_ack); end
        tick();  // E2
        checks++; if ({c_ack, c_dout} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_ack: ack/dout got %b/%h expected 1/a5", c_ack, c_dout); end
        c_req = 1'b0; c_we = 1'b0;
        exp_c_dout = 8'hA5;
        tick();
        checks++; if ({c_ack, busy} !== 2'b00) begin errors++; $display("FAIL rd_done: ack/busy got %b expected 00", {c_ack, busy}); end
        $display("txn cpu rd addr=%h data=%h", a, c_dout);
    endtask

    task automatic test_video_read;
        logic [AW-1:0] a;
        a = 19'h0_4000;
        sram_mem[a] = 8'h3C;
        ref_mem[a]  = 8'h3C;
        v_req = 1'b1; v_addr = a; tb_drive = 1'b1;
        tick();
        checks++; if ({sram_addr, sram_we_n, v_ack} !== {a, 1'b1, 1'b0})
            begin errors++; $display("FAIL vid_addr: addr/we_n/ack got %h/%b/%b expected %h/1/0", sram_addr, sram_we_n, v_ack, a); end
        v_addr = 19'h7_1234;
        tick();
        checks++; if ({sram_we_n, v_ack} !== 2'b10) begin errors++; $display("FAIL vid_mid: we_n/ack got %b expected 10", {sram_we_n, v_ack}); end
        tick();
        checks++; if ({v_ack, v_dout, c_ack, sram_we_n} !== {1'b1, 8'h3C, 1'b0, 1'b1})
            begin errors++; $display("FAIL vid_ack: ack/dout/c_ack/we_n got %b/%h/%b/%b expected 1/3c/0/1", v_ack, v_dout, c_ack, sram_we_n); end
        checks++; if (c_dout !== exp_c_dout) begin errors++; $display("FAIL vid_cdout: got %h expected %h", c_dout, exp_c_dout); end
        v_req = 1'b0;
        exp_v_dout = 8'h3C;
        tick();
        checks++; if ({v_ack, busy} !== 2'b00) begin errors++; $display("FAIL vid_done: ack/busy got %b expected 00", {v_ack, busy}); end
        $display("txn video rd addr=%h data=%h", a, v_dout);
    endtask

    task automatic test_reset_mid_write;
        logic [AW-1:0] a;
        logic [7:0]    old_d;
        logic [7:0]    d;
        a = 19'h2_AAAA;
        old_d = sram_peek(a);
        d = ~old_d;
        c_req = 1'b1; c_we = 1'b1; c_addr = a; c_din = d; tb_drive = 1'b0;
        tick();
        tick();
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midwr_pulse: we_n got %b expected 0", sram_we_n); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({sram_we_n, busy, v_ack, c_ack} !== 4'b1000)
            begin errors++; $display("FAIL midwr_rst: we_n/busy/v_ack/c_ack got %b expected 1000", {sram_we_n, busy, v_ack, c_ack}); end
        checks++; if (sram_data === d) begin errors++; $display("FAIL midwr_data: still driven %h", sram_data); end
        c_req = 1'b0; c_we = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({busy, sram_we_n, v_ack, c_ack} !== 4'b0100)
                begin errors++; $display("FAIL midwr_idle: busy/we_n/v_ack/c_ack got %b expected 0100", {busy, sram_we_n, v_ack, c_ack}); end
        end
        checks++; if (sram_peek(a) !== old_d) begin errors++; $display("FAIL midwr_mem: got %h expected %h", sram_peek(a), old_d); end
        exp_v_dout = 8'h00;
        exp_c_dout = 8'h00;
        $display("txn cpu wr addr=%h aborted by reset", a);
    endtask

    // Both ports queue transactions and keep req high until their queue drains.
    task automatic run_traffic(input int nv, input int nc, input bit allow_wr);
        txn_t vq[$];
        txn_t cq[$];
        txn_t exp_q[$];
        int   s, mv, mc, vi, ci, k, budget, busy_cnt, wel_cnt, after_ack;
        got_order.delete();
        for (int i = 0; i < nv; i++) begin
            txn_t t;
            t.port = 1'b0; t.we = 1'b0;
            t.addr = 19'h7_FF00 | AW'($urandom_range(0, 7));
            t.data = 8'h00;
            vq.push_back(t);
        end
        for (int i = 0; i < nc; i++) begin
            txn_t t;
            t.port = 1'b1;
            t.we   = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
            t.addr = 19'h7_FF00 | AW'($urandom_range(0, 7));
            t.data = 8'($urandom);
            cq.push_back(t);
        end
        s = 0; mv = 0; mc = 0;
        while (mv < nv || mc < nc) begin
            txn_t t;
            logic pick_c;
            if (mv < nv && mc < nc) pick_c = (s == LIM);
            else pick_c = (mc < nc);
            if (pick_c) begin
                t = cq[mc]; mc++; s = 0;
            end else begin
                t = vq[mv]; mv++;
                s = (mc < nc) ? ((s < LIM) ? s + 1 : s) : 0;
            end
            if (t.we) ref_mem[t.addr] = t.data;
            else t.data = ref_peek(t.addr);
            exp_q.push_back(t);
        end

        vi = 0; ci = 0; k = 0; budget = 0; busy_cnt = 0; wel_cnt = 0; after_ack = 0;
        tb_drive = (exp_q.size() > 0) ? !exp_q[0].we : 1'b0;
        if (nv > 0) begin v_req = 1'b1; v_addr = vq[0].addr; end
        if (nc > 0) begin c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_din = cq[0].data; end
        while (k < exp_q.size() && budget < 8 * exp_q.size() + 10) begin
            tick();
            budget++;
            if (busy) busy_cnt++;
            if (!sram_we_n) wel_cnt++;
            if (after_ack == 1) begin
                checks++; if ({v_ack, c_ack, busy} !== 3'b000)
                    begin errors++; $display("FAIL gap_idle: v_ack/c_ack/busy got %b expected 000", {v_ack, c_ack, busy}); end
                after_ack = 2;
            end else if (after_ack == 2) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_regrant: busy got %b expected 1", busy); end
                after_ack = 0;
            end
            if (busy_cnt == 1 && !(v_ack || c_ack)) begin
                if (exp_q[k].port) begin c_addr = ~c_addr; c_din = ~c_din; end
                else v_addr = ~v_addr;
            end
            if (v_ack || c_ack) begin
                got_order.push_back(c_ack);
                checks++; if ((v_ack && c_ack) || c_ack !== exp_q[k].port)
                    begin errors++; $display("FAIL txn%0d_port: v_ack/c_ack got %b%b expected port %0d", k, v_ack, c_ack, exp_q[k].port); end
                if (!exp_q[k].we) begin
                    if (exp_q[k].port) exp_c_dout = exp_q[k].data;
                    else exp_v_dout = exp_q[k].data;
                end
                checks++; if ({v_dout, c_dout} !== {exp_v_dout, exp_c_dout})
                    begin errors++; $display("FAIL txn%0d_data: v_dout/c_dout got %h/%h expected %h/%h", k, v_dout, c_dout, exp_v_dout, exp_c_dout); end
                checks++; if (busy_cnt !== (exp_q[k].we ? 4 : 3))
                    begin errors++; $display("FAIL txn%0d_latency: busy cycles got %0d expected %0d", k, busy_cnt, exp_q[k].we ? 4 : 3); end
                checks++; if (wel_cnt !== (exp_q[k].we ? 1 : 0))
                    begin errors++; $display("FAIL txn%0d_we_pulse: low cycles got %0d expected %0d", k, wel_cnt, exp_q[k].we ? 1 : 0); end
                $display("txn %0d: %s %s addr=%h data=%h", k, exp_q[k].port ? "cpu" : "video",
                         exp_q[k].we ? "wr" : "rd", exp_q[k].addr, exp_q[k].data);
                if (c_ack) begin
                    ci++;
                    if (ci < nc) begin c_we = cq[ci].we; c_addr = cq[ci].addr; c_din = cq[ci].data; end
                    else c_req = 1'b0;
                end else begin
                    vi++;
                    if (vi < nv) v_addr = vq[vi].addr;
                    else v_req = 1'b0;
                end
                k++;
                busy_cnt = 0; wel_cnt = 0; after_ack = 1;
                tb_drive = (k < exp_q.size()) ? !exp_q[k].we : 1'b0;
            end
        end
        if (k < exp_q.size()) begin
            checks++; errors++;
            $display("FAIL traffic_timeout: acks got %0d expected %0d", k, exp_q.size());
        end
        v_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
        tick(); tick();
    endtask

    task automatic test_first_after_reset;
        test_reset();
        run_traffic(1, 1, 1'b0);
        checks++; if (got_order.size() != 2 || got_order[0] !== 1'b0 || got_order[1] !== 1'b1)
            begin errors++; $display("FAIL first_order: got %p expected V then C", got_order); end
    endtask

    task automatic test_starvation;
        logic pat [6];
        logic ok;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        run_traffic(4, 2, 1'b0);
        ok = (got_order.size() == 6);
        for (int i = 0; i < 6 && ok; i++) if (got_order[i] !== pat[i]) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL starve_order: got %p expected V V C V V C", got_order); end
    endtask

    task automatic test_random_traffic;
        for (int r = 0; r < 8; r++) begin
            run_traffic($urandom_range(0, 4), $urandom_range(1, 3), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_video_read();
        test_reset_mid_write();
        test_first_after_reset();
        test_starvation();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
